ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Registers the 159-bit decode-to-execute bus and evaluates the one-hot ALU.
- Owns the HI/LO registers, a single-cycle multiplier and a 32-iteration radix-2 divider FSM.
- Drives the data SRAM request, the execute-to-memory bus, and the forwarding and load-use signals back to decode.

Parameters:
- ID_TO_EX_WD, 159, width of the decode-to-execute bus.
- EX_TO_MEM_WD, 76, width of the execute-to-memory bus.
- DIV_ITER, 32, number of divider iterations.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  pipeline stall vector; 1 = Stop; bit 2 = this stage, bit 3 = memory stage.
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_val[63:32], rt_val[31:0]}.
- ex_to_mem_bus  out  76  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], result[31:0]}.
- ex_to_id_forwarding  out  38  {rf_we, rf_waddr, result}.
- ex_aluop  out  1  load in EX: ram_en & (ram_wen==0).
- stallreq_for_ex  out  1  divider busy.
- data_sram_en  out  1  equals ram_en.
- data_sram_wen  out  4  equals ram_wen.
- data_sram_addr  out  32  equals result.
- data_sram_wdata  out  32  equals rt_val.

Behaviour:
- Pipeline register:
  - Async clear when rst=0.
  - Posedge: if stall[2]=Stop and stall[3]=NoStop, load zeros (bubble); else if stall[2]=NoStop, load id_to_ex_bus; else hold.
- Reset values: every output is 0; HI=LO=0; divider FSM in IDLE.
- src1 select:
  - sel_src1[0]: rs_val.
  - [1]: pc.
  - [2]: zero-extended inst[10:6].
  - none set: 0.
- src2 select:
  - sel_src2[0]: rt_val.
  - [1]: sign-extended inst[15:0].
  - [2]: 32'd8.
  - [3]: zero-extended inst[15:0].
  - none set: 0.
- alu_op is one-hot, MSB first: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts shift src2 by src1[4:0].
  - lui = src2<<16.
  - Add/sub wrap modulo 2^32; no overflow trap.
  - All-zero alu_op gives 0.
- HI/LO instructions are decoded locally from inst (opcode 0), by funct:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
  - 0x10 MFHI, 0x12 MFLO, 0x11 MTHI, 0x13 MTLO.
- MFHI/MFLO:
  - result = HI/LO.
  - rf_we forced to 1 and rf_waddr forced to inst[15:11], overriding the bus fields.
- HI/LO writes (MULT/MULTU, MTHI, MTLO):
  - MULT/MULTU: 64-bit product, {HI,LO} = product.
  - MTHI/MTLO: HI/LO = rs_val.
  - Commit on the clock edge where stall[2]=NoStop.
  - A following MFHI/MFLO reads the new value with no bypass required.
- Divider FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: DIV/DIVU with nonzero rt_val present -> latch |rs|, |rt| (DIVU: raw values) and result signs; go to RUN. stallreq_for_ex=1 combinationally in this cycle.
  - RUN: one restoring shift-subtract step per cycle, counting DIV_ITER steps; stallreq_for_ex=1. After the last step, go to DONE.
  - DONE: stallreq_for_ex=0.
    - Signed fix-up: quotient negated if operand signs differ; remainder takes the dividend's sign.
    - HI=remainder, LO=quotient commit on the edge leaving DONE.
    - DONE -> IDLE only when stall[2]=NoStop; otherwise hold in DONE with no restart.
  - Latency: stallreq_for_ex is high for 33 cycles, i.e. the instruction occupies EX for 34 cycles.
  - Divide by zero: no FSM start, no stall, HI/LO unchanged.
- rst=0 mid-divide: FSM returns to IDLE, stallreq_for_ex drops immediately, HI/LO cleared.
- sel_rf_res and ram_en/ram_wen pass through unchanged.

Test Plan:
- ADDU rs_val=0xFFFFFFFF, rt_val=1, sel_src1=001, sel_src2=0001, alu_op add, rf_waddr=5 -> next cycle result=0, ex_to_id_forwarding={1,5,0}.
- LW with rs_val=0x1000, imm=0xFFFC, ram_en=1, wen=0 -> data_sram_addr=0x0FFC, ex_aluop=1; SW with rt_val=0xAB -> wen=1111, wdata=0xAB.
- MULT rs=0xFFFFFFFE (-2), rt=3, then MFLO rd=8, then MFHI rd=9 -> results 0xFFFFFFFA then 0xFFFFFFFF, rf_we=1.
- DIV rs=-7, rt=2 -> stallreq_for_ex high exactly 33 cycles; MFLO gives 0xFFFFFFFD, MFHI gives 0xFFFFFFFF; DIVU 7/2 gives LO=3, HI=1.
- DIV with rt=0 -> no stall; HI/LO retain prior values. rst pulse at RUN cycle 10 -> stallreq_for_ex=0, outputs 0, HI=LO=0.
- stall[2]=Stop with stall[3]=NoStop -> bubble: ex_to_mem_bus=0. stall[2] and stall[3] both Stop during DONE -> FSM holds DONE, no second divide.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_stage
// Brief   : MIPS execute stage: one-hot ALU, HI/LO, multiplier, radix-2 divider
// Revision: 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int DIV_ITER     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id_forwarding,
  output logic                    ex_aluop,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIV_ITER - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [5:0] c_fn_mfhi  = 6'h10;
  localparam logic [5:0] c_fn_mthi  = 6'h11;
  localparam logic [5:0] c_fn_mflo  = 6'h12;
  localparam logic [5:0] c_fn_mtlo  = 6'h13;
  localparam logic [5:0] c_fn_mult  = 6'h18;
  localparam logic [5:0] c_fn_multu = 6'h19;
  localparam logic [5:0] c_fn_div   = 6'h1A;
  localparam logic [5:0] c_fn_divu  = 6'h1B;

  logic [ID_TO_EX_WD-1:0] r_bus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus <= '0;
    end else if (stall[2] && !stall[3]) begin
      r_bus <= '0;
    end else if (!stall[2]) begin
      r_bus <= id_to_ex_bus;
    end
  end

  logic [31:0] w_pc, w_inst, w_rs_val, w_rt_val;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel_src1;
  logic [3:0]  w_sel_src2;
  logic        w_ram_en, w_rf_we, w_sel_rf_res;
  logic [3:0]  w_ram_wen;
  logic [4:0]  w_rf_waddr;

  assign w_pc         = r_bus[158:127];
  assign w_inst       = r_bus[126:95];
  assign w_alu_op     = r_bus[94:83];
  assign w_sel_src1   = r_bus[82:80];
  assign w_sel_src2   = r_bus[79:76];
  assign w_ram_en     = r_bus[75];
  assign w_ram_wen    = r_bus[74:71];
  assign w_rf_we      = r_bus[70];
  assign w_rf_waddr   = r_bus[69:65];
  assign w_sel_rf_res = r_bus[64];
  assign w_rs_val     = r_bus[63:32];
  assign w_rt_val     = r_bus[31:0];

  logic w_special;
  logic w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
  logic w_is_mult, w_is_multu, w_is_div, w_is_divu;

  assign w_special  = (w_inst[31:26] == 6'd0);
  assign w_is_mfhi  = w_special && (w_inst[5:0] == c_fn_mfhi);
  assign w_is_mflo  = w_special && (w_inst[5:0] == c_fn_mflo);
  assign w_is_mthi  = w_special && (w_inst[5:0] == c_fn_mthi);
  assign w_is_mtlo  = w_special && (w_inst[5:0] == c_fn_mtlo);
  assign w_is_mult  = w_special && (w_inst[5:0] == c_fn_mult);
  assign w_is_multu = w_special && (w_inst[5:0] == c_fn_multu);
  assign w_is_div   = w_special && (w_inst[5:0] == c_fn_div);
  assign w_is_divu  = w_special && (w_inst[5:0] == c_fn_divu);

  logic [31:0] w_src1, w_src2;

  assign w_src1 = ({32{w_sel_src1[0]}} & w_rs_val)
                | ({32{w_sel_src1[1]}} & w_pc)
                | ({32{w_sel_src1[2]}} & {27'd0, w_inst[10:6]});

  assign w_src2 = ({32{w_sel_src2[0]}} & w_rt_val)
                | ({32{w_sel_src2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                | ({32{w_sel_src2[2]}} & 32'd8)
                | ({32{w_sel_src2[3]}} & {16'd0, w_inst[15:0]});

  logic [31:0] w_add, w_sub, w_slt, w_sltu, w_sll, w_srl, w_sra, w_lui, w_alu_res;

  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = {31'd0, $signed(w_src1) < $signed(w_src2)};
  assign w_sltu = {31'd0, w_src1 < w_src2};
  assign w_sll  = w_src2 << w_src1[4:0];
  assign w_srl  = w_src2 >> w_src1[4:0];
  assign w_sra  = $unsigned($signed(w_src2) >>> w_src1[4:0]);
  assign w_lui  = {w_src2[15:0], 16'd0};

  // one-hot select: an all-zero alu_op naturally yields zero
  assign w_alu_res = ({32{w_alu_op[11]}} & w_add)
                   | ({32{w_alu_op[10]}} & w_sub)
                   | ({32{w_alu_op[9]}}  & w_slt)
                   | ({32{w_alu_op[8]}}  & w_sltu)
                   | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                   | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                   | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                   | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                   | ({32{w_alu_op[3]}}  & w_sll)
                   | ({32{w_alu_op[2]}}  & w_srl)
                   | ({32{w_alu_op[1]}}  & w_sra)
                   | ({32{w_alu_op[0]}}  & w_lui);

  logic [63:0] w_prod_s, w_prod_u;

  // low 64 bits of the sign-extended product equal the signed product
  assign w_prod_s = {{32{w_rs_val[31]}}, w_rs_val} * {{32{w_rt_val[31]}}, w_rt_val};
  assign w_prod_u = {32'd0, w_rs_val} * {32'd0, w_rt_val};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rem, r_quo, r_dvs;
  logic             r_neg_q, r_neg_r;
  logic [31:0]      r_hi, r_lo;

  logic        w_div_start, w_ge;
  logic [31:0] w_rs_abs, w_rt_abs, w_div_q, w_div_r;
  logic [32:0] w_shift, w_trial;

  assign w_div_start = (w_is_div || w_is_divu) && (w_rt_val != 32'd0) && (r_state == c_st_idle);
  assign w_rs_abs    = (w_is_div && w_rs_val[31]) ? (32'd0 - w_rs_val) : w_rs_val;
  assign w_rt_abs    = (w_is_div && w_rt_val[31]) ? (32'd0 - w_rt_val) : w_rt_val;
  assign w_shift     = {r_rem, r_quo[31]};
  assign w_trial     = w_shift - {1'b0, r_dvs};
  assign w_ge        = ~w_trial[32];
  assign w_div_q     = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_div_r     = r_neg_r ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_div_start) begin
            r_rem   <= 32'd0;
            r_quo   <= w_rs_abs;
            r_dvs   <= w_rt_abs;
            r_neg_q <= w_is_div && (w_rs_val[31] ^ w_rt_val[31]);
            r_neg_r <= w_is_div && w_rs_val[31];
            r_cnt   <= '0;
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          r_rem <= w_ge ? w_trial[31:0] : w_shift[31:0];
          r_quo <= {r_quo[30:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_cnt_last) begin
            r_state <= c_st_done;
          end
        end
        c_st_done: begin
          if (!stall[2]) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == c_st_done && !stall[2]) begin
      r_hi <= w_div_r;
      r_lo <= w_div_q;
    end else if (!stall[2]) begin
      if (w_is_mult) begin
        {r_hi, r_lo} <= w_prod_s;
      end else if (w_is_multu) begin
        {r_hi, r_lo} <= w_prod_u;
      end else if (w_is_mthi) begin
        r_hi <= w_rs_val;
      end else if (w_is_mtlo) begin
        r_lo <= w_rs_val;
      end
    end
  end

  logic [31:0] w_result;
  logic        w_rf_we_eff;
  logic [4:0]  w_rf_waddr_eff;

  assign w_result       = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : w_alu_res);
  assign w_rf_we_eff    = w_rf_we | w_is_mfhi | w_is_mflo;
  assign w_rf_waddr_eff = (w_is_mfhi || w_is_mflo) ? w_inst[15:11] : w_rf_waddr;

  assign ex_to_mem_bus       = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res,
                                w_rf_we_eff, w_rf_waddr_eff, w_result};
  assign ex_to_id_forwarding = {w_rf_we_eff, w_rf_waddr_eff, w_result};
  assign ex_aluop            = w_ram_en && (w_ram_wen == 4'd0);
  assign stallreq_for_ex     = w_div_start || (r_state == c_st_run);
  assign data_sram_en        = w_ram_en;
  assign data_sram_wen       = w_ram_wen;
  assign data_sram_addr      = w_result;
  assign data_sram_wdata     = w_rt_val;

  logic w_unused;
  assign w_unused = &{1'b0, stall[5:4], stall[1:0], w_inst[25:16]};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_stage
// Brief   : Self-checking bench for ex_stage against an arithmetic reference
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_forwarding;
  logic         ex_aluop;
  logic         stallreq_for_ex;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .id_to_ex_bus        (id_to_ex_bus),
    .ex_to_mem_bus       (ex_to_mem_bus),
    .ex_to_id_forwarding (ex_to_id_forwarding),
    .ex_aluop            (ex_aluop),
    .stallreq_for_ex     (stallreq_for_ex),
    .data_sram_en        (data_sram_en),
    .data_sram_wen       (data_sram_wen),
    .data_sram_addr      (data_sram_addr),
    .data_sram_wdata     (data_sram_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [158:0] mk_bus(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
    input logic [3:0] wen, input logic rf_we, input logic [4:0] wa,
    input logic sel_rf, input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ram_en, wen, rf_we, wa, sel_rf, rs, rt};
  endfunction

  function automatic logic [31:0] hilo_inst(input logic [5:0] funct, input logic [4:0] rd);
    return {6'd0, 5'd3, 5'd4, rd, 5'd0, funct};
  endfunction

  // reference ALU: k = 0..11 in the order add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
  function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    case (k)
      0:  return a + b;
      1:  return a + (~b) + 32'd1;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << sh;
      9:  return b >> sh;
      10: return b[31] ? ~((~b) >> sh) : (b >> sh);
      default: return {b[15:0], 16'd0};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hilo(input logic [5:0] funct, input logic [4:0] rd,
                            input logic [31:0] rs, input logic [31:0] rt);
    id_to_ex_bus = mk_bus(32'h0040_0100, hilo_inst(funct, rd), 12'd0, 3'd0, 4'd0,
                          1'b0, 4'd0, 1'b0, 5'd0, 1'b0, rs, rt);
    stall = 6'd0;
    step();
  endtask

  // issues DIV/DIVU and lets it run to DONE; cyc = cycles stallreq was seen high
  task automatic run_div(input logic is_signed, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
    longint sa, sb, q, r;
    id_to_ex_bus = mk_bus(32'h0040_0200, hilo_inst(is_signed ? 6'h1A : 6'h1B, 5'd0), 12'd0,
                          3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, a, b);
    stall = 6'd0;
    step();
    cyc = 0;
    while (stallreq_for_ex === 1'b1 && cyc < 100) begin
      cyc++;
      stall = 6'b001111;
      step();
    end
    stall = 6'd0;
    if (b != 32'd0) begin
      if (is_signed) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        m_lo = 32'(q);
        m_hi = 32'(r);
      end else begin
        m_lo = a / b;
        m_hi = a % b;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall = 6'd0;
    id_to_ex_bus = mk_bus($urandom, $urandom, 12'h800, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1,
                          5'd9, 1'b1, $urandom, $urandom);
    repeat (3) step();
    checks++;
    if (ex_to_mem_bus !== 76'd0) begin
      failures++;
      $display("FAIL reset_bus: got %h expected 0", ex_to_mem_bus);
    end
    checks++;
    if ({ex_to_id_forwarding, ex_aluop, stallreq_for_ex, data_sram_en, data_sram_wen,
         data_sram_addr, data_sram_wdata} !== 110'd0) begin
      failures++;
      $display("FAIL reset_outputs: got fwd=%h aluop=%b stallreq=%b en=%b wen=%h addr=%h wdata=%h expected all 0",
               ex_to_id_forwarding, ex_aluop, stallreq_for_ex, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    id_to_ex_bus = '0;
  endtask

  task automatic test_alu();
    logic [31:0] pc, inst, rs, rt, a, b, res;
    logic        ram_en, rf_we, sel_rf;
    logic [3:0]  wen;
    logic [4:0]  wa;
    int          k, i1, i2;

    id_to_ex_bus = mk_bus(32'h0040_0000, 32'h00A4_2821, 12'h800, 3'b001, 4'b0001, 1'b0, 4'd0,
                          1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF, 32'd1);
    stall = 6'd0;
    step();
    checks++;
    if (ex_to_id_forwarding !== {1'b1, 5'd5, 32'd0}) begin
      failures++;
      $display("FAIL addu_fwd: got %h expected %h", ex_to_id_forwarding, {1'b1, 5'd5, 32'd0});
    end
    checks++;
    if (ex_to_mem_bus !== {32'h0040_0000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'd0}) begin
      failures++;
      $display("FAIL addu_bus: got %h expected %h", ex_to_mem_bus,
               {32'h0040_0000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'd0});
    end

    for (int it = 0; it < 24; it++) begin
      k = $urandom_range(0, 11);
      i1 = $urandom_range(0, 3);
      i2 = $urandom_range(0, 4);
      pc = $urandom; rs = $urandom; rt = $urandom;
      inst = {6'h09, 26'($urandom)};
      ram_en = 1'($urandom); wen = 4'($urandom); rf_we = 1'($urandom);
      wa = 5'($urandom); sel_rf = 1'($urandom);
      case (i1)
        0: a = rs;
        1: a = pc;
        2: a = {27'd0, inst[10:6]};
        default: a = 32'd0;
      endcase
      case (i2)
        0: b = rt;
        1: b = {{16{inst[15]}}, inst[15:0]};
        2: b = 32'd8;
        3: b = {16'd0, inst[15:0]};
        default: b = 32'd0;
      endcase
      res = ref_alu(k, a, b);
      id_to_ex_bus = mk_bus(pc, inst, 12'h800 >> k, (i1 == 3) ? 3'd0 : (3'd1 << i1),
                            (i2 == 4) ? 4'd0 : (4'd1 << i2), ram_en, wen, rf_we, wa, sel_rf, rs, rt);
      step();
      checks++;
      if (ex_to_mem_bus !== {pc, ram_en, wen, sel_rf, rf_we, wa, res}) begin
        failures++;
        $display("FAIL alu_bus op=%0d s1=%0d s2=%0d: got %h expected %h", k, i1, i2,
                 ex_to_mem_bus, {pc, ram_en, wen, sel_rf, rf_we, wa, res});
      end
      checks++;
      if ({ex_to_id_forwarding, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_aluop}
          !== {rf_we, wa, res, ram_en, wen, res, rt, (ram_en && wen == 4'd0)}) begin
        failures++;
        $display("FAIL alu_side op=%0d: got fwd=%h en=%b wen=%h addr=%h wdata=%h aluop=%b expected fwd=%h addr=%h wdata=%h",
                 k, ex_to_id_forwarding, data_sram_en, data_sram_wen, data_sram_addr,
                 data_sram_wdata, ex_aluop, {rf_we, wa, res}, res, rt);
      end
    end
  endtask

  task automatic test_mem();
    id_to_ex_bus = mk_bus(32'h0040_0010, {6'h23, 5'd1, 5'd2, 16'hFFFC}, 12'h800, 3'b001, 4'b0010,
                          1'b1, 4'd0, 1'b1, 5'd2, 1'b1, 32'h0000_1000, 32'h55);
    stall = 6'd0;
    step();
    checks++;
    if ({data_sram_addr, ex_aluop, data_sram_en, data_sram_wen} !== {32'h0000_0FFC, 1'b1, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL lw: got addr=%h aluop=%b en=%b wen=%h expected addr=00000ffc aluop=1 en=1 wen=0",
               data_sram_addr, ex_aluop, data_sram_en, data_sram_wen);
    end
    id_to_ex_bus = mk_bus(32'h0040_0014, {6'h2B, 5'd1, 5'd2, 16'h0010}, 12'h800, 3'b001, 4'b0010,
                          1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_2000, 32'hAB);
    step();
    checks++;
    if ({data_sram_wen, data_sram_wdata, data_sram_addr, ex_aluop} !== {4'hF, 32'hAB, 32'h2010, 1'b0}) begin
      failures++;
      $display("FAIL sw: got wen=%h wdata=%h addr=%h aluop=%b expected wen=f wdata=000000ab addr=00002010 aluop=0",
               data_sram_wen, data_sram_wdata, data_sram_addr, ex_aluop);
    end
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    logic [63:0] p;
    int          sel;
    drive_hilo(6'h18, 5'd0, 32'hFFFF_FFFE, 32'd3);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
    drive_hilo(6'h12, 5'd8, 32'd0, 32'd0);
    checks++;
    if (ex_to_id_forwarding !== {1'b1, 5'd8, 32'hFFFF_FFFA}) begin
      failures++;
      $display("FAIL mult_mflo: got %h expected %h", ex_to_id_forwarding, {1'b1, 5'd8, 32'hFFFF_FFFA});
    end
    drive_hilo(6'h10, 5'd9, 32'd0, 32'd0);
    checks++;
    if (ex_to_id_forwarding !== {1'b1, 5'd9, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL mult_mfhi: got %h expected %h", ex_to_id_forwarding, {1'b1, 5'd9, 32'hFFFF_FFFF});
    end

    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 3);
      a = $urandom; b = $urandom;
      case (sel)
        0: begin
          p = 64'(longint'($signed(a)) * longint'($signed(b)));
          drive_hilo(6'h18, 5'd0, a, b);
          {m_hi, m_lo} = p;
        end
        1: begin
          p = 64'(a) * 64'(b);
          drive_hilo(6'h19, 5'd0, a, b);
          {m_hi, m_lo} = p;
        end
        2: begin
          drive_hilo(6'h11, 5'd0, a, b);
          m_hi = a;
        end
        default: begin
          drive_hilo(6'h13, 5'd0, a, b);
          m_lo = a;
        end
      endcase
      drive_hilo(6'h10, 5'd17, 32'd0, 32'd0);
      checks++;
      if (ex_to_id_forwarding !== {1'b1, 5'd17, m_hi}) begin
        failures++;
        $display("FAIL hilo_mfhi sel=%0d a=%h b=%h: got %h expected %h", sel, a, b,
                 ex_to_id_forwarding, {1'b1, 5'd17, m_hi});
      end
      drive_hilo(6'h12, 5'd18, 32'd0, 32'd0);
      checks++;
      if (ex_to_id_forwarding !== {1'b1, 5'd18, m_lo}) begin
        failures++;
        $display("FAIL hilo_mflo sel=%0d a=%h b=%h: got %h expected %h", sel, a, b,
                 ex_to_id_forwarding, {1'b1, 5'd18, m_lo});
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] as[6];
    logic [31:0] bs[6];
    logic        sg[6];
    int          cyc;
    as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2; sg[0] = 1'b1;
    as[1] = 32'd7;         bs[1] = 32'd2; sg[1] = 1'b0;
    as[2] = $urandom;      bs[2] = $urandom_range(1, 50); sg[2] = 1'b1;
    as[3] = $urandom;      bs[3] = 32'hFFFF_FFFF - $urandom_range(0, 40); sg[3] = 1'b1;
    as[4] = $urandom;      bs[4] = $urandom_range(1, 1000); sg[4] = 1'b0;
    as[5] = 32'h8000_0000; bs[5] = 32'hFFFF_FFFF; sg[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_div(sg[i], as[i], bs[i], cyc);
      checks++;
      if (cyc != 33) begin
        failures++;
        $display("FAIL div_latency a=%h b=%h: got %0d stall cycles expected 33", as[i], bs[i], cyc);
      end
      drive_hilo(6'h12, 5'd20, 32'd0, 32'd0);
      checks++;
      if (ex_to_id_forwarding !== {1'b1, 5'd20, m_lo}) begin
        failures++;
        $display("FAIL div_lo signed=%b a=%h b=%h: got %h expected %h", sg[i], as[i], bs[i],
                 ex_to_id_forwarding[31:0], m_lo);
      end
      drive_hilo(6'h10, 5'd21, 32'd0, 32'd0);
      checks++;
      if (ex_to_id_forwarding !== {1'b1, 5'd21, m_hi}) begin
        failures++;
        $display("FAIL div_hi signed=%b a=%h b=%h: got %h expected %h", sg[i], as[i], bs[i],
                 ex_to_id_forwarding[31:0], m_hi);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    m_hi = $urandom; m_lo = $urandom;
    drive_hilo(6'h11, 5'd0, m_hi, 32'd0);
    drive_hilo(6'h13, 5'd0, m_lo, 32'd0);
    run_div(1'b1, 32'd1234, 32'd0, cyc);
    checks++;
    if (cyc != 0) begin
      failures++;
      $display("FAIL divzero_stall: got %0d stall cycles expected 0", cyc);
    end
    drive_hilo(6'h12, 5'd1, 32'd0, 32'd0);
    checks++;
    if (ex_to_id_forwarding[31:0] !== m_lo) begin
      failures++;
      $display("FAIL divzero_lo: got %h expected %h", ex_to_id_forwarding[31:0], m_lo);
    end
    drive_hilo(6'h10, 5'd1, 32'd0, 32'd0);
    checks++;
    if (ex_to_id_forwarding[31:0] !== m_hi) begin
      failures++;
      $display("FAIL divzero_hi: got %h expected %h", ex_to_id_forwarding[31:0], m_hi);
    end
  endtask

  task automatic test_reset_mid_div();
    drive_hilo(6'h11, 5'd0, 32'hDEAD_BEEF, 32'd0);
    drive_hilo(6'h13, 5'd0, 32'h1234_5678, 32'd0);
    id_to_ex_bus = mk_bus(32'h0040_0300, hilo_inst(6'h1B, 5'd0), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0,
                          1'b0, 5'd0, 1'b0, 32'd1000, 32'd3);
    stall = 6'd0;
    step();
    stall = 6'b001111;
    repeat (10) step();
    checks++;
    if (stallreq_for_ex !== 1'b1) begin
      failures++;
      $display("FAIL rstdiv_running: got stallreq=%b expected 1", stallreq_for_ex);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({stallreq_for_ex, ex_to_mem_bus, ex_to_id_forwarding} !== 115'd0) begin
      failures++;
      $display("FAIL rstdiv_clear: got stallreq=%b bus=%h fwd=%h expected all 0",
               stallreq_for_ex, ex_to_mem_bus, ex_to_id_forwarding);
    end
    @(negedge clk);
    rst = 1'b1;
    stall = 6'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    drive_hilo(6'h10, 5'd10, 32'd0, 32'd0);
    checks++;
    if (ex_to_id_forwarding !== {1'b1, 5'd10, 32'd0}) begin
      failures++;
      $display("FAIL rstdiv_hi: got %h expected %h", ex_to_id_forwarding, {1'b1, 5'd10, 32'd0});
    end
    drive_hilo(6'h12, 5'd11, 32'd0, 32'd0);
    checks++;
    if (ex_to_id_forwarding !== {1'b1, 5'd11, 32'd0}) begin
      failures++;
      $display("FAIL rstdiv_lo: got %h expected %h", ex_to_id_forwarding, {1'b1, 5'd11, 32'd0});
    end
  endtask

  task automatic test_bubble();
    logic [75:0] exp_bus;
    id_to_ex_bus = mk_bus(32'h0040_0400, 32'h2400_0000, 12'h800, 3'b001, 4'b0001, 1'b0, 4'd0,
                          1'b1, 5'd7, 1'b0, 32'd5, 32'd6);
    exp_bus = {32'h0040_0400, 1'b0, 4'd0, 1'b0, 1'b1, 5'd7, 32'd11};
    stall = 6'd0;
    step();
    id_to_ex_bus = mk_bus($urandom, 32'h2400_0000, 12'h400, 3'b010, 4'b0001, 1'b1, 4'hF,
                          1'b1, 5'd3, 1'b1, $urandom, $urandom);
    stall = 6'b001100;
    step();
    checks++;
    if (ex_to_mem_bus !== exp_bus) begin
      failures++;
      $display("FAIL stall_hold: got %h expected %h", ex_to_mem_bus, exp_bus);
    end
    stall = 6'b000100;
    step();
    checks++;
    if (ex_to_mem_bus !== 76'd0) begin
      failures++;
      $display("FAIL bubble: got %h expected 0", ex_to_mem_bus);
    end
    stall = 6'd0;
  endtask

  task automatic test_done_hold();
    int cyc;
    run_div(1'b0, 32'd100, 32'd7, cyc);
    checks++;
    if (cyc != 33) begin
      failures++;
      $display("FAIL hold_latency: got %0d stall cycles expected 33", cyc);
    end
    stall = 6'b001100;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (stallreq_for_ex !== 1'b0) begin
        failures++;
        $display("FAIL done_hold_%0d: got stallreq=%b expected 0", i, stallreq_for_ex);
      end
    end
    drive_hilo(6'h12, 5'd12, 32'd0, 32'd0);
    checks++;
    if (ex_to_id_forwarding !== {1'b1, 5'd12, 32'd14}) begin
      failures++;
      $display("FAIL hold_lo: got %h expected %h", ex_to_id_forwarding, {1'b1, 5'd12, 32'd14});
    end
    drive_hilo(6'h10, 5'd13, 32'd0, 32'd0);
    checks++;
    if (ex_to_id_forwarding !== {1'b1, 5'd13, 32'd2}) begin
      failures++;
      $display("FAIL hold_hi: got %h expected %h", ex_to_id_forwarding, {1'b1, 5'd13, 32'd2});
    end
  endtask

  initial begin
    rst = 1'b0;
    stall = 6'd0;
    id_to_ex_bus = '0;
    test_reset();
    test_alu();
    test_mem();
    test_mult();
    test_div();
    test_div_zero();
    test_reset_mid_div();
    test_bubble();
    test_done_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
